// File: rtl/dcache_port_arbiter_if.sv
// +-----------------------------------------------------------------------------
// | Module   : dcache_port_arbiter_if
// | Brief    : LSU, page-table walker and D-cache port signals for the arbiter.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

interface dcache_port_arbiter_if #(
    parameter int DATA_W = 64
);
    logic              lsu_req_valid;
    logic              lsu_req_ready;
    logic [DATA_W-1:0] lsu_req_addr;
    logic              lsu_req_write;
    logic [DATA_W-1:0] lsu_req_wdata;
    logic              lsu_resp_valid;
    logic [DATA_W-1:0] lsu_resp_data;

    logic              walk_req_valid;
    logic [DATA_W-1:0] walk_req_addr;
    logic              walk_resp_valid;
    logic [DATA_W-1:0] walk_resp_data;

    logic              dc_req_valid;
    logic              dc_req_ready;
    logic [DATA_W-1:0] dc_req_addr;
    logic              dc_req_write;
    logic [DATA_W-1:0] dc_req_wdata;
    logic              dc_req_phys;
    logic              dc_resp_valid;
    logic [DATA_W-1:0] dc_resp_data;

    logic              err_spurious;

    // master: the arbiter itself
    modport master (
        input  lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata,
        input  walk_req_valid, walk_req_addr,
        input  dc_req_ready, dc_resp_valid, dc_resp_data,
        output lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        output walk_resp_valid, walk_resp_data,
        output dc_req_valid, dc_req_addr, dc_req_write, dc_req_wdata, dc_req_phys,
        output err_spurious
    );

    // slave: the requesters and the D-cache around the arbiter
    modport slave (
        output lsu_req_valid, lsu_req_addr, lsu_req_write, lsu_req_wdata,
        output walk_req_valid, walk_req_addr,
        output dc_req_ready, dc_resp_valid, dc_resp_data,
        input  lsu_req_ready, lsu_resp_valid, lsu_resp_data,
        input  walk_resp_valid, walk_resp_data,
        input  dc_req_valid, dc_req_addr, dc_req_write, dc_req_wdata, dc_req_phys,
        input  err_spurious
    );
endinterface

`default_nettype wire

// File: rtl/dcache_port_arbiter.sv
// +-----------------------------------------------------------------------------
// | Module   : dcache_port_arbiter
// | Brief    : Shares one D-cache port between LSU and PTW with bounded LSU wait.
// | Revision : 1.0 - initial release
// +-----------------------------------------------------------------------------
`default_nettype none

module dcache_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 64
) (
    input  wire logic              clk,
    input  wire logic              reset,
    dcache_port_arbiter_if.master  bus
);

    localparam logic [1:0] C_ST_IDLE  = 2'd0;
    localparam logic [1:0] C_ST_ISSUE = 2'd1;
    localparam logic [1:0] C_ST_WAIT  = 2'd2;

    localparam logic       C_OWN_LSU  = 1'b0;
    localparam logic       C_OWN_WALK = 1'b1;

    localparam logic [3:0] C_LIMIT    = 4'(STARVE_LIMIT);

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic [3:0]        starve_cnt_q, starve_cnt_d;
    logic [DATA_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              write_q, write_d;
    logic              phys_q, phys_d;

    logic              w_idle;
    logic              w_grant_walk;
    logic              w_grant_lsu;
    logic              w_resp_hit;

    assign w_idle       = (state_q == C_ST_IDLE);
    // The walker keeps priority until a waiting LSU has been passed over STARVE_LIMIT times.
    assign w_grant_walk = w_idle && bus.walk_req_valid &&
                          (!bus.lsu_req_valid || (starve_cnt_q < C_LIMIT));
    assign w_grant_lsu  = w_idle && bus.lsu_req_valid && !w_grant_walk;
    assign w_resp_hit   = (state_q == C_ST_WAIT) && bus.dc_resp_valid;

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        starve_cnt_d = starve_cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        write_d      = write_q;
        phys_d       = phys_q;

        case (state_q)
            C_ST_IDLE: begin
                if (w_grant_walk) begin
                    state_d = C_ST_ISSUE;
                    owner_d = C_OWN_WALK;
                    addr_d  = bus.walk_req_addr;
                    wdata_d = '0;
                    write_d = 1'b0;
                    phys_d  = 1'b1;
                    if (bus.lsu_req_valid) begin
                        starve_cnt_d = (starve_cnt_q == C_LIMIT) ? starve_cnt_q
                                                                 : starve_cnt_q + 4'd1;
                    end else begin
                        starve_cnt_d = 4'd0;
                    end
                end else if (w_grant_lsu) begin
                    state_d      = C_ST_ISSUE;
                    owner_d      = C_OWN_LSU;
                    addr_d       = bus.lsu_req_addr;
                    wdata_d      = bus.lsu_req_wdata;
                    write_d      = bus.lsu_req_write;
                    phys_d       = 1'b0;
                    starve_cnt_d = 4'd0;
                end
            end
            C_ST_ISSUE: begin
                if (bus.dc_req_ready) begin
                    state_d = C_ST_WAIT;
                end
            end
            C_ST_WAIT: begin
                if (bus.dc_resp_valid) begin
                    state_d = C_ST_IDLE;
                end
            end
            default: begin
                state_d = C_ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= C_ST_IDLE;
            owner_q      <= C_OWN_LSU;
            starve_cnt_q <= 4'd0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
            phys_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            starve_cnt_q <= starve_cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            write_q      <= write_d;
            phys_q       <= phys_d;
        end
    end

    // Outputs fed straight from inputs are held low while reset is asserted.
    assign bus.lsu_req_ready   = reset && w_grant_lsu;
    assign bus.err_spurious    = reset && bus.dc_resp_valid && (state_q != C_ST_WAIT);

    assign bus.dc_req_valid    = (state_q == C_ST_ISSUE);
    assign bus.dc_req_addr     = addr_q;
    assign bus.dc_req_write    = write_q;
    assign bus.dc_req_wdata    = wdata_q;
    assign bus.dc_req_phys     = phys_q;

    assign bus.lsu_resp_valid  = w_resp_hit && (owner_q == C_OWN_LSU);
    assign bus.walk_resp_valid = w_resp_hit && (owner_q == C_OWN_WALK);
    assign bus.lsu_resp_data   = bus.lsu_resp_valid  ? bus.dc_resp_data : '0;
    assign bus.walk_resp_data  = bus.walk_resp_valid ? bus.dc_resp_data : '0;

endmodule

`default_nettype wire

// File: doc/dcache_port_arbiter.md
Name: dcache_port_arbiter

Overview:
- Shares the single D-cache request port between the load/store unit (LSU) and the MMU page-table walker.
- The walker normally has priority; the LSU is guaranteed service after a bounded number of consecutive walker grants.
- Allows one outstanding D$ transaction at a time, routes each response back to the requester that owns it, and forces physical-mode addressing for walker fetches.

Parameters:
- STARVE_LIMIT, 4, maximum number of consecutive walker grants while an LSU request is pending (range 1..15).
- DATA_W, 64, width of address and data paths.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-low reset.
- lsu_req_valid  in  1  LSU request; held stable until accepted.
- lsu_req_ready  out  1  LSU request accepted this cycle.
- lsu_req_addr  in  64  LSU virtual/physical address.
- lsu_req_write  in  1  1 = store.
- lsu_req_wdata  in  64  store data.
- lsu_resp_valid  out  1  one-cycle pulse: response for LSU.
- lsu_resp_data  out  64  load data.
- walk_req_valid  in  1  walker level request (the walker's use_dcache signal).
- walk_req_addr  in  64  PTE address; 8-byte aligned.
- walk_resp_valid  out  1  one-cycle pulse: PTE returned.
- walk_resp_data  out  64  PTE data.
- dc_req_valid  out  1  request to D$.
- dc_req_ready  in  1  D$ accepts the request.
- dc_req_addr  out  64  latched address.
- dc_req_write  out  1  latched write flag; always 0 for walker.
- dc_req_wdata  out  64  latched store data.
- dc_req_phys  out  1  1 = bypass translation; set for walker transactions.
- dc_resp_valid  in  1  D$ response.
- dc_resp_data  in  64  D$ response data.
- err_spurious  out  1  one-cycle pulse: dc_resp_valid seen while not in WAIT_RESP.

Behaviour:
- Reset (reset = 0, asynchronous):
  - state = IDLE, owner = 0, starve_cnt = 0, all latched request fields = 0.
  - Every output is 0.
- States: IDLE, ISSUE, WAIT_RESP.
- IDLE:
  - If walk_req_valid and (!lsu_req_valid or starve_cnt < STARVE_LIMIT): grant walker. owner = WALK; latch walk_req_addr; write = 0; phys = 1.
  - Else if lsu_req_valid: grant LSU. owner = LSU; latch addr, write and wdata; phys = 0.
  - lsu_req_ready pulses for one cycle in the LSU grant cycle only.
  - Any grant moves to ISSUE at the next edge.
- ISSUE:
  - dc_req_valid = 1 with the latched fields.
  - The fields stay stable until dc_req_ready.
  - On dc_req_valid and dc_req_ready, move to WAIT_RESP.
- WAIT_RESP:
  - On dc_resp_valid, combinationally drive lsu_resp_valid or walk_resp_valid (per owner) with dc_resp_data in the same cycle, then go to IDLE.
  - The non-owner resp_valid stays 0. Both resp_data outputs are 0 when their valid is 0.
  - A response in the same cycle as the ISSUE handshake is not legal; the D$ has at least 1 cycle of latency.
- Latency:
  - Request sampled in IDLE at cycle N; dc_req_valid first high at N+1.
  - Response is forwarded in 0 cycles.
  - Minimum turnaround is 3 cycles per transaction: IDLE, ISSUE, WAIT_RESP.
- Starvation counter:
  - On a walker grant while lsu_req_valid = 1: starve_cnt increments, saturating at STARVE_LIMIT.
  - On any LSU grant: starve_cnt = 0.
  - On a walker grant while lsu_req_valid = 0: starve_cnt = 0.
- Simultaneous requests with starve_cnt == STARVE_LIMIT: LSU wins, and the walker waits (its level request stays high).
- Walker withdraw: walk_req_valid is sampled only in IDLE. A drop after grant does not cancel the transaction; the response is still delivered as a walk_resp_valid pulse.
- LSU fields are latched at grant, so later changes on lsu_req_* do not affect the transaction in flight.
- dc_resp_valid in IDLE or ISSUE is dropped (nothing forwarded) and pulses err_spurious.
- Reset mid-transaction: returns to IDLE immediately. A late D$ response after reset release is a spurious response (err_spurious).

Test Plan:
- Walker only: walk_req_valid = 1, addr = 0x8000_1238; D$ ready at once, response 0x0000_0000_2000_00CF two cycles later:
  - dc_req_valid at N+1 with addr 0x8000_1238, phys = 1, write = 0.
  - walk_resp_valid pulses with 0x...200000CF; lsu_resp_valid stays 0.
- LSU store: addr 0x1000, wdata 0xDEAD_BEEF, write = 1; D$ holds ready low for 3 cycles:
  - lsu_req_ready pulses once.
  - dc_req_* stay stable for 4 cycles.
  - lsu_resp_valid pulses on the response.
- Contention with STARVE_LIMIT = 4: both requesters held continuously:
  - Grant order is W, W, W, W, L, W, W, W, W, L.
  - starve_cnt resets to 0 after each L grant.
- Walker address changes after each response (4-level walk, 4 distinct PTE addresses), LSU idle:
  - 4 walker transactions, each with the new address.
  - No LSU grant, and no extra dc request after the walker drops walk_req_valid.
- Reset asserted in WAIT_RESP, then dc_resp_valid 2 cycles after release:
  - All outputs 0 during reset.
  - err_spurious pulses once; no resp_valid.
- Spurious dc_resp_valid in IDLE with no requests: err_spurious = 1 for 1 cycle; state stays IDLE.
